// File: rtl/cont_pkg.sv
// cont_pkg: state encodings and default timing constants for the continue-button conditioner
package cont_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 20000000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser with asynchronous active-high reset
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, s1} <= 2'b00;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/continue_conditioner.sv
// continue_conditioner: synchronise, debounce and pulse the raw continue button.
// Define CONT_AUTOREPEAT_EN to emit auto-repeat pulses while the button stays held.
module continue_conditioner
  import cont_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse_out,
  output logic level_out,
  output logic bouncing
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic s2, pulse_nxt, pulse_d;
  sync_2ff u_sync (.clk(clk), .reset(reset), .d(btn_in), .q(s2));
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    pulse_nxt = 1'b0;
    case (state)
      IDLE:
        if (s2) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt = '0;
        end
      PRESS_WAIT:
        if (!s2) state_nxt = IDLE;
        else if (cnt == CMAX) begin
          state_nxt = HELD;
          pulse_nxt = 1'b1;
        end else cnt_nxt = cnt + 1'b1;
      HELD:
        if (!s2) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt = '0;
        end
      default:
        if (s2) state_nxt = HELD;
        else if (cnt == CMAX) state_nxt = IDLE;
        else cnt_nxt = cnt + 1'b1;
    endcase
  end
`ifdef CONT_AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPER = RW'(REPEAT_PERIOD - 1);
  logic [RW-1:0] rcnt;
  logic rep, in_held, rep_hit;
  // counting only while HELD persists makes any release bounce restart the delay
  assign in_held = state == HELD && state_nxt == HELD;
  assign rep_hit = in_held && rcnt == (rep ? RPER : RDLY);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rcnt <= '0;
      rep <= 1'b0;
    end else if (!in_held) begin
      rcnt <= '0;
      rep <= 1'b0;
    end else if (rep_hit) begin
      rcnt <= '0;
      rep <= 1'b1;
    end else rcnt <= rcnt + 1'b1;
  assign pulse_d = pulse_nxt | (rep_hit & ~pulse_out);
`else
  logic unused_rep;
  assign unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign pulse_d = pulse_nxt;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pulse_out <= 1'b0;
      level_out <= 1'b0;
      bouncing <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      pulse_out <= pulse_d;
      level_out <= state_nxt == HELD || state_nxt == RELEASE_WAIT;
      bouncing <= state_nxt == PRESS_WAIT || state_nxt == RELEASE_WAIT;
    end
endmodule
